// File: rtl/reg_bank_4x8_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_4x8_pkg
// Shared constants for the 4x8 register bank, the operand-select mux and the
// control unit.
//   REG_W      : register data width
//   REG_CNT    : number of general registers
//   REG_IDX_W  : register index width
//   R0..R3     : register index constants (same encoding as the mux select)
//   idx_decode : index -> one-hot register select
// -----------------------------------------------------------------------------
package reg_bank_4x8_pkg;

  localparam int REG_W     = 8;
  localparam int REG_CNT   = 4;
  localparam int REG_IDX_W = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t R0 = 2'd0;
  localparam reg_idx_t R1 = 2'd1;
  localparam reg_idx_t R2 = 2'd2;
  localparam reg_idx_t R3 = 2'd3;

  // One-hot decode of a register index.
  function automatic logic [REG_CNT-1:0] idx_decode(input reg_idx_t idx);
    logic [REG_CNT-1:0] sel;
    sel      = {REG_CNT{1'b0}};
    sel[idx] = 1'b1;
    return sel;
  endfunction

endpackage : reg_bank_4x8_pkg

// File: rtl/reg_bank_4x8_reg_cell.sv
// -----------------------------------------------------------------------------
// reg_cell
// One WIDTH-bit register of the bank with write enable, synchronous
// active-high reset, a sticky "written" flag and a registered zero flag.
// Ports:
//   clk     : system clock, rising edge
//   reset   : synchronous active-high reset (overrides a write)
//   we      : write enable
//   wdata   : write data
//   q       : stored value
//   written : set on the first write after reset, cleared only by reset
//   zero    : registered (q == 0)
// -----------------------------------------------------------------------------
module reg_cell
  import reg_bank_4x8_pkg::*;
#(
  parameter int               WIDTH     = REG_W,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q,
  output logic             written,
  output logic             zero
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             written_d, written_q;
  logic             zero_d, zero_q;

  // Next-state: load on write, otherwise hold; zero tracks the next value so
  // it changes on the same edge as the data.
  always_comb begin
    data_d    = data_q;
    written_d = written_q;
    if (we) begin
      data_d    = wdata;
      written_d = 1'b1;
    end else begin
      data_d    = data_q;
      written_d = written_q;
    end
    zero_d = (data_d == {WIDTH{1'b0}});
  end

  // State registers with synchronous reset taking priority over writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= RESET_VAL;
      written_q <= 1'b0;
      zero_q    <= (RESET_VAL == {WIDTH{1'b0}});
    end else begin
      data_q    <= data_d;
      written_q <= written_d;
      zero_q    <= zero_d;
    end
  end

  assign q       = data_q;
  assign written = written_q;
  assign zero    = zero_q;

endmodule : reg_cell

// File: rtl/reg_bank_4x8.sv
// -----------------------------------------------------------------------------
// reg_bank_4x8
// Four general registers r0..r3 feeding the ALU operand-select mux.
// Two write sources: ALU write-back (fire-and-forget) and an external load
// port with valid/ready handshake. On a same-address collision write-back
// wins and the load is stalled (ld_ready=0) until the loader retries.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   wb_en, wb_addr, wb_data    : ALU write-back strobe / index / data
//   ld_valid, ld_addr, ld_data : external load request
//   ld_ready                   : load accepted this cycle (combinational)
//   r0..r3                     : register contents to the mux
//   written                    : sticky per-register written flags
//   zero                       : per-register (ri == 0) flags
// Build option:
//   REG_BANK_BYPASS_EN : when defined, r0..r3 and zero forward the winning
//                        write of the current cycle combinationally (0-cycle
//                        latency); stored state is identical either way.
// -----------------------------------------------------------------------------
module reg_bank_4x8
  import reg_bank_4x8_pkg::*;
#(
  parameter int               WIDTH     = REG_W,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]     wb_data,
  input  logic                 ld_valid,
  input  logic [REG_IDX_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]     ld_data,
  output logic                 ld_ready,
  output logic [WIDTH-1:0]     r0,
  output logic [WIDTH-1:0]     r1,
  output logic [WIDTH-1:0]     r2,
  output logic [WIDTH-1:0]     r3,
  output logic [REG_CNT-1:0]   written,
  output logic [REG_CNT-1:0]   zero
);

  logic               conflict_s;
  logic               ld_ready_s;
  logic               ld_fire_s;
  logic [REG_CNT-1:0] wb_sel_s;
  logic [REG_CNT-1:0] ld_sel_s;
  logic [REG_CNT-1:0] we_s;
  logic [WIDTH-1:0]   wdata_s [REG_CNT];
  logic [WIDTH-1:0]   q_s     [REG_CNT];
  logic [WIDTH-1:0]   out_s   [REG_CNT];
  logic [REG_CNT-1:0] written_s;
  logic [REG_CNT-1:0] zero_reg_s;
  logic [REG_CNT-1:0] zero_out_s;

  // Handshake and arbitration: a load only stalls when write-back targets
  // the same register; ld_ready depends on inputs only, never on itself.
  always_comb begin
    conflict_s = wb_en & ld_valid & (wb_addr == ld_addr);
    ld_ready_s = ~reset & ~conflict_s;
    ld_fire_s  = ld_valid & ld_ready_s;
    if (wb_en) begin
      wb_sel_s = idx_decode(wb_addr);
    end else begin
      wb_sel_s = {REG_CNT{1'b0}};
    end
    if (ld_fire_s) begin
      ld_sel_s = idx_decode(ld_addr);
    end else begin
      ld_sel_s = {REG_CNT{1'b0}};
    end
  end

  // Per-register write enable and data select (write-back has priority).
  always_comb begin
    we_s = {REG_CNT{1'b0}};
    for (int i = 0; i < REG_CNT; i++) begin
      we_s[i] = wb_sel_s[i] | ld_sel_s[i];
      if (wb_sel_s[i]) begin
        wdata_s[i] = wb_data;
      end else begin
        wdata_s[i] = ld_data;
      end
    end
  end

  for (genvar g = 0; g < REG_CNT; g++) begin : g_cell
    reg_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .we      (we_s[g]),
      .wdata   (wdata_s[g]),
      .q       (q_s[g]),
      .written (written_s[g]),
      .zero    (zero_reg_s[g])
    );
  end

`ifdef REG_BANK_BYPASS_EN
  // Forward the write that will land on the next edge; nothing lands during
  // reset, so the stored value is shown then.
  always_comb begin
    zero_out_s = zero_reg_s;
    for (int i = 0; i < REG_CNT; i++) begin
      if (we_s[i] & ~reset) begin
        out_s[i]      = wdata_s[i];
        zero_out_s[i] = (wdata_s[i] == {WIDTH{1'b0}});
      end else begin
        out_s[i]      = q_s[i];
        zero_out_s[i] = zero_reg_s[i];
      end
    end
  end
`else
  // Pure register outputs.
  always_comb begin
    zero_out_s = zero_reg_s;
    for (int i = 0; i < REG_CNT; i++) begin
      out_s[i] = q_s[i];
    end
  end
`endif

  assign ld_ready = ld_ready_s;
  assign r0       = out_s[R0];
  assign r1       = out_s[R1];
  assign r2       = out_s[R2];
  assign r3       = out_s[R3];
  assign written  = written_s;
  assign zero     = zero_out_s;

endmodule : reg_bank_4x8

// File: tb/tb_reg_bank_4x8.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_4x8
// Self-checking bench for reg_bank_4x8 (default build): directed scenarios
// followed by randomized traffic, compared against an array-based model of
// the register file built from the behavioural rules.
// -----------------------------------------------------------------------------
module tb_reg_bank_4x8;

  logic       clk;
  logic       reset;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       ld_valid;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic [7:0] r0, r1, r2, r3;
  logic [3:0] written;
  logic [3:0] zero;

  // Reference model state.
  logic [7:0] m_reg [4];
  logic       m_wr  [4];
  logic       accepted;

  int n_total;
  int n_pass;

  reg_bank_4x8 dut (
    .clk      (clk),
    .reset    (reset),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .r0       (r0),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3),
    .written  (written),
    .zero     (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One clock: check ld_ready before the edge, advance the model on the
  // edge, then check every register output.
  task automatic step();
    logic       exp_rdy;
    logic [3:0] exp_w;
    logic [3:0] exp_z;
    #1;
    exp_rdy = !reset && !(wb_en && ld_valid && (wb_addr == ld_addr));
    check("ld_ready", {31'd0, ld_ready}, {31'd0, exp_rdy});
    accepted = ld_valid && exp_rdy;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_reg[i] = 8'h00;
        m_wr[i]  = 1'b0;
      end
    end else begin
      if (accepted) begin
        m_reg[ld_addr] = ld_data;
        m_wr[ld_addr]  = 1'b1;
      end
      if (wb_en) begin
        m_reg[wb_addr] = wb_data;
        m_wr[wb_addr]  = 1'b1;
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_w[i] = m_wr[i];
      exp_z[i] = (m_reg[i] == 8'h00);
    end
    check("r0", {24'd0, r0}, {24'd0, m_reg[0]});
    check("r1", {24'd0, r1}, {24'd0, m_reg[1]});
    check("r2", {24'd0, r2}, {24'd0, m_reg[2]});
    check("r3", {24'd0, r3}, {24'd0, m_reg[3]});
    check("written", {28'd0, written}, {28'd0, exp_w});
    check("zero", {28'd0, zero}, {28'd0, exp_z});
  endtask

  task automatic drive(input logic rst, input logic we, input logic [1:0] wa, input logic [7:0] wd,
                       input logic lv, input logic [1:0] la, input logic [7:0] ldd);
    reset    = rst;
    wb_en    = we;
    wb_addr  = wa;
    wb_data  = wd;
    ld_valid = lv;
    ld_addr  = la;
    ld_data  = ldd;
  endtask

  initial begin
    logic       pend;
    n_total  = 0;
    n_pass   = 0;
    accepted = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_reg[i] = 8'hxx;
      m_wr[i]  = 1'bx;
    end
    drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);

    // Reset for two cycles.
    step();
    step();
    check("rst_written", {28'd0, written}, 32'h0);
    check("rst_zero", {28'd0, zero}, 32'hF);

    // Write-back r2 = A5.
    drive(1'b0, 1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 8'h00);
    step();
    check("wb_r2", {24'd0, r2}, 32'hA5);
    check("wb_written", {28'd0, written}, 32'h4);
    check("wb_zero", {28'd0, zero}, 32'hB);

    // Load r1 = 3C, accepted first edge.
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h3C);
    step();
    check("ld_r1", {24'd0, r1}, 32'h3C);
    check("ld_written1", {31'd0, written[1]}, 32'h1);

    // Conflict on r3: write-back wins, load retried.
    drive(1'b0, 1'b1, 2'd3, 8'h11, 1'b1, 2'd3, 8'h22);
    step();
    check("conf_r3_wb", {24'd0, r3}, 32'h11);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'h22);
    step();
    check("conf_r3_ld", {24'd0, r3}, 32'h22);

    // Parallel writes to different registers.
    drive(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 2'd1, 8'hFF);
    step();
    check("par_zero0", {31'd0, zero[0]}, 32'h1);
    check("par_zero1", {31'd0, zero[1]}, 32'h0);
    check("par_r1", {24'd0, r1}, 32'hFF);

    // Idle hold.
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    step();

    // Reset overrides both writes.
    drive(1'b1, 1'b1, 2'd2, 8'h77, 1'b1, 2'd1, 8'h55);
    step();
    check("rmid_r1", {24'd0, r1}, 32'h0);
    check("rmid_r2", {24'd0, r2}, 32'h0);
    check("rmid_written", {28'd0, written}, 32'h0);

    // Randomized traffic with a compliant loader.
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      reset   = ($urandom_range(0, 31) == 0);
      wb_en   = ($urandom_range(0, 1) == 1);
      wb_addr = 2'($urandom_range(0, 3));
      wb_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if (!pend) begin
        ld_valid = ($urandom_range(0, 1) == 1);
        ld_addr  = 2'($urandom_range(0, 3));
        ld_data  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end else begin
        ld_valid = 1'b1;
      end
      step();
      pend = ld_valid && !accepted;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_reg_bank_4x8
